// File: rtl/hc595_scan_ctrl.sv
// Multiplexed 7-segment scan driver feeding a 16-bit 74HC595 chain ({digit select, segments}).
// Optional build macro HC595_SCAN_BLANK_EN inserts an all-off transfer before every digit to suppress ghosting.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_LOAD     | one cycle: form {sel, seg} (or 16'hFFFF in a blank slot)
// S_SHIFT_LO | sr_clk low for CLK_DIV cycles, sr_data holds the current bit
// S_SHIFT_HI | sr_clk high for CLK_DIV cycles, chain samples sr_data
// S_LATCH    | sr_latch high for CLK_DIV cycles
// S_DWELL    | digit held lit for DWELL cycles, then advance digit_idx
module hc595_scan_ctrl #(
  parameter int CLK_DIV    = 2,
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [8*NUM_DIGITS-1:0] upd_data,
  output logic                    sr_data,
  output logic                    sr_clk,
  output logic                    sr_latch,
  output logic [2:0]              digit_idx,
  output logic                    frame_done
);

`ifdef HC595_SCAN_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  localparam logic [15:0] CNT_DIV   = 16'(CLK_DIV - 1);
  localparam logic [15:0] CNT_DWELL = 16'(DWELL - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_DWELL
  } state_t;

  state_t state, state_nxt;

  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [15:0] word, word_nxt;
  logic        sr_data_nxt;
  logic [2:0]  digit_idx_nxt;
  logic        blank, blank_nxt;

  logic [8*NUM_DIGITS-1:0] active_buf;
  logic [8*NUM_DIGITS-1:0] shadow_buf;
  logic                    shadow_full;

  logic [7:0]  seg_cur;
  logic [7:0]  sel_cur;
  logic [15:0] load_word;

  always_comb begin
    seg_cur = 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == 3'(i)) seg_cur = active_buf[8*i +: 8];
    end
  end

  assign sel_cur   = ~(8'b1 << digit_idx);
  assign load_word = blank ? 16'hFFFF : {sel_cur, seg_cur};

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_cnt_nxt   = bit_cnt;
    word_nxt      = word;
    sr_data_nxt   = sr_data;
    digit_idx_nxt = digit_idx;
    blank_nxt     = blank;
    frame_done    = 1'b0;

    case (state)
      S_LOAD: begin
        word_nxt    = load_word;
        sr_data_nxt = load_word[15];
        bit_cnt_nxt = 4'd15;
        cnt_nxt     = CNT_DIV;
        state_nxt   = S_SHIFT_LO;
      end

      S_SHIFT_LO: begin
        if (cnt == 16'd0) begin
          cnt_nxt   = CNT_DIV;
          state_nxt = S_SHIFT_HI;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end

      S_SHIFT_HI: begin
        if (cnt == 16'd0) begin
          cnt_nxt = CNT_DIV;
          if (bit_cnt == 4'd0) begin
            state_nxt = S_LATCH;
          end else begin
            // word[15] is always the bit on the wire; shift the next one up
            bit_cnt_nxt = bit_cnt - 4'd1;
            word_nxt    = {word[14:0], 1'b0};
            sr_data_nxt = word[14];
            state_nxt   = S_SHIFT_LO;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end

      S_LATCH: begin
        if (cnt == 16'd0) begin
          if (blank) begin
            blank_nxt = 1'b0;
            state_nxt = S_LOAD;
          end else begin
            cnt_nxt   = CNT_DWELL;
            state_nxt = S_DWELL;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end

      S_DWELL: begin
        if (cnt == 16'd0) begin
          state_nxt = S_LOAD;
          blank_nxt = BLANK_EN;
          if (digit_idx == LAST_IDX) begin
            frame_done    = 1'b1;
            digit_idx_nxt = 3'd0;
          end else begin
            digit_idx_nxt = digit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end

      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      cnt       <= 16'd0;
      bit_cnt   <= 4'd0;
      word      <= 16'd0;
      sr_data   <= 1'b0;
      sr_clk    <= 1'b0;
      sr_latch  <= 1'b0;
      digit_idx <= 3'd0;
      blank     <= BLANK_EN;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      word      <= word_nxt;
      sr_data   <= sr_data_nxt;
      sr_clk    <= (state_nxt == S_SHIFT_HI);
      sr_latch  <= (state_nxt == S_LATCH);
      digit_idx <= digit_idx_nxt;
      blank     <= blank_nxt;
    end
  end

  // Shadow is drained at the frame boundary before a new offer can land, so
  // an offer in the frame_done cycle (shadow empty) only fills the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_buf  <= {NUM_DIGITS{8'hFF}};
      shadow_buf  <= {NUM_DIGITS{8'hFF}};
      shadow_full <= 1'b0;
    end else if (frame_done && shadow_full) begin
      active_buf  <= shadow_buf;
      shadow_full <= 1'b0;
    end else if (upd_valid && !shadow_full) begin
      shadow_buf  <= upd_data;
      shadow_full <= 1'b1;
    end
  end

  assign upd_ready = ~shadow_full;

endmodule
